mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port, byte-array data RAM between two requesters: the
//  MEM stage (D port) and the instruction-fetch/debug loader (I port).
//  Sits between the pipeline and the RAM. Latches one request and issues a
//  single-cycle read or write enable to the RAM. Waits out the RAM's
//  registered-read latency, then returns data with a one-cycle ack.
//  A requester stalls while it holds req high and has not yet seen ack.
// PARAMETERS
//  ADDR_W    32  requester/RAM address width
//  DATA_W    32  word width
//  RAM_LAT   1   cycles from RAM enable edge until ram_rdata is valid (>=1)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous reset, active-high
//  d_req      in   1       D-port request; held high until d_ack
//  d_we       in   1       D-port 1=write, 0=read
//  d_addr     in   ADDR_W  D-port byte address
//  d_wdata    in   DATA_W  D-port write data
//  d_rdata    out  DATA_W  D-port read data, valid while d_ack=1
//  d_ack      out  1       D-port one-cycle completion pulse
//  i_req/i_we/i_addr/i_wdata/i_rdata/i_ack   same as the D port, for the I port
//  ram_addr   out  ADDR_W  to RAM; word aligned: {addr[ADDR_W-1:2],2'b00}
//  ram_wdata  out  DATA_W  to RAM write data
//  ram_r_en   out  1       to RAM read enable; one-cycle pulse
//  ram_w_en   out  1       to RAM write enable; one-cycle pulse
//  ram_rdata  in   DATA_W  from RAM registered read data
//  busy       out  1       high in every state except IDLE
// BEHAVIOUR
//  - Reset (async, any cycle): state=IDLE; all outputs 0; latched addr,
//    wdata, we, owner, wait counter and read buffer cleared.
//  - Reset mid-transaction abandons it. No enable or ack is produced.
//    A write whose enable pulse was already issued remains in RAM.
//  - FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: if d_req or i_req is high, choose a winner; latch its we, addr and
//    wdata and the owner ID; go to ISSUE. Otherwise stay in IDLE.
//  - ISSUE (1 cycle): drive ram_addr/ram_wdata from the latched values.
//    Assert ram_w_en=we, ram_r_en=~we. Load cnt=RAM_LAT; go to WAIT.
//  - WAIT: enables are 0 and ram_addr is held. Decrement cnt each cycle.
//    In the cycle with cnt==1, capture ram_rdata into the buffer and go to RESP.
//  - RESP (1 cycle): the owner's ack=1 and the owner's rdata=buffer.
//    The other port's ack=0. Go to IDLE. Requests are not sampled in RESP.
//  - Writes use the same timing; on a write ack, rdata is don't-care (drive 0).
//  - Latency from req seen in IDLE to ack = RAM_LAT+2 cycles (3 at default).
//    Peak throughput is one transaction per RAM_LAT+3 cycles.
//  - The requester deasserts req on the clock edge where it samples ack.
//    A req still high in the following IDLE is a new transaction.
//  - Simultaneous d_req and i_req in IDLE: arbitration rule, see CONFIGURATION.
//    The loser keeps req high and is granted in a later IDLE.
//  - Requester inputs that change after the grant are ignored until the next
//    IDLE (values are latched).
//  - rdata outputs are 0 whenever the matching ack is 0.
//  - d_ack and i_ack are never high in the same cycle.
//  - Exactly one enable pulse is issued per transaction.
//  - addr[1:0] is dropped; RAM address wrap is the RAM's concern.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, D wins every tie.
//    I can starve while d_req stays continuously high.
//  MEM_ARB_ROUND_ROBIN_EN defined: a 1-bit last_grant register, reset to I.
//    On a tie, grant the port not granted last. last_grant updates at every
//    grant. A lone request is always granted regardless of last_grant.
// TESTING
//  1 D write 0x10<-0xDEADBEEF, then D read 0x10 -> ram_w_en pulse in cycle 1;
//    read d_ack at +3 with d_rdata=0xDEADBEEF; i_ack stays 0.
//  2 D read at 0x13 after a write to 0x10 -> ram_addr=0x10; same data returned.
//  3 d_req and i_req both held high for 4 transactions.
//    Fixed priority: D,D,D,D and i_ack never seen.
//    With MEM_ARB_ROUND_ROBIN_EN: D,I,D,I.
//  4 RAM_LAT=3: read -> ack exactly 5 cycles after grant; ram_r_en high 1 cycle.
//  5 rst pulsed while in WAIT -> all outputs 0 immediately.
//    No ack follows. A next request completes normally.
//  6 Requester changes d_addr/d_wdata during WAIT -> RAM sees the originally
//    latched values; busy=1 from ISSUE through RESP.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, registered-read data RAM between
// the D port (MEM stage) and the I port (fetch/debug loader). One request is
// latched at a time and walked through IDLE -> ISSUE -> WAIT -> RESP.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, D wins every tie
//   defined   : round-robin tie-break using a 1-bit last-grant register
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    // D port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    // I port
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    // RAM side
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_r_en,
    output logic              ram_w_en,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = (RAM_LAT < 2) ? 1 : $clog2(RAM_LAT + 1);
    // Word alignment: the two byte-offset bits never reach the RAM.
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(3));
    localparam logic OWNER_D = 1'b0;
    localparam logic OWNER_I = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e              r_state;
    logic                r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_rbuf;
    logic                r_ram_r_en;
    logic                r_ram_w_en;
    logic                r_d_ack;
    logic                r_i_ack;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                r_last_grant;
`endif

    logic                w_any_req;
    logic                w_grant_i;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;

    // Pick the winning port for a request seen in IDLE (1 = I port).
    always_comb begin
        w_grant_i = OWNER_D;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (d_req && i_req) begin
            w_grant_i = ~r_last_grant;
        end else begin
            w_grant_i = i_req;
        end
`else
        w_grant_i = i_req & ~d_req;
`endif
    end

    assign w_any_req = d_req | i_req;
    assign w_we      = w_grant_i ? i_we    : d_we;
    assign w_addr    = w_grant_i ? i_addr  : d_addr;
    assign w_wdata   = w_grant_i ? i_wdata : d_wdata;

    // Transaction FSM; enables and acks are registered so they line up with
    // the ISSUE and RESP states respectively.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_owner      <= OWNER_D;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_rbuf       <= '0;
            r_ram_r_en   <= 1'b0;
            r_ram_w_en   <= 1'b0;
            r_d_ack      <= 1'b0;
            r_i_ack      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_grant <= OWNER_I;
`endif
        end else begin
            // Enables and acks are single-cycle pulses.
            r_ram_r_en <= 1'b0;
            r_ram_w_en <= 1'b0;
            r_d_ack    <= 1'b0;
            r_i_ack    <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_owner    <= w_grant_i;
                        r_we       <= w_we;
                        r_addr     <= w_addr & ADDR_MASK;
                        r_wdata    <= w_wdata;
                        r_ram_w_en <= w_we;
                        r_ram_r_en <= ~w_we;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        r_last_grant <= w_grant_i;
`endif
                        r_state    <= StIssue;
                    end
                end
                StIssue: begin
                    r_cnt   <= CNT_W'(RAM_LAT);
                    r_state <= StWait;
                end
                StWait: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_rbuf  <= ram_rdata;
                        r_d_ack <= (r_owner == OWNER_D);
                        r_i_ack <= (r_owner == OWNER_I);
                        r_state <= StResp;
                    end
                end
                StResp: begin
                    // Requests are deliberately not sampled here.
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign ram_r_en  = r_ram_r_en;
    assign ram_w_en  = r_ram_w_en;
    assign busy      = (r_state != StIdle);
    assign d_ack     = r_d_ack;
    assign i_ack     = r_i_ack;
    // Read data only shows while the matching ack is up, and never on writes.
    assign d_rdata   = (r_d_ack && !r_we) ? r_rbuf : '0;
    assign i_rdata   = (r_i_ack && !r_we) ? r_rbuf : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A RAM_LAT=1 instance carries
// most scenarios through a scoreboard; a RAM_LAT=3 instance covers latency.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // RAM_LAT=1 instance signals
    logic        d_req = 0, d_we = 0, i_req = 0, i_we = 0;
    logic [31:0] d_addr = 0, d_wdata = 0, i_addr = 0, i_wdata = 0;
    logic [31:0] d_rdata, i_rdata, ram_addr, ram_wdata;
    logic [31:0] ram_rdata = 0;
    logic        d_ack, i_ack, ram_r_en, ram_w_en, busy;

    // RAM_LAT=3 instance signals
    logic        d3_req = 0, d3_we = 0, i3_req = 0, i3_we = 0;
    logic [31:0] d3_addr = 0, d3_wdata = 0, i3_addr = 0, i3_wdata = 0;
    logic [31:0] d3_rdata, i3_rdata, r3_addr, r3_wdata;
    logic        d3_ack, i3_ack, r3_r_en, r3_w_en, busy3;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ack(i_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_r_en(ram_r_en),
        .ram_w_en(ram_w_en), .ram_rdata(ram_rdata), .busy(busy)
    );

    logic [31:0] r3_rdata;
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
        .d_rdata(d3_rdata), .d_ack(d3_ack),
        .i_req(i3_req), .i_we(i3_we), .i_addr(i3_addr), .i_wdata(i3_wdata),
        .i_rdata(i3_rdata), .i_ack(i3_ack),
        .ram_addr(r3_addr), .ram_wdata(r3_wdata), .ram_r_en(r3_r_en),
        .ram_w_en(r3_w_en), .ram_rdata(r3_rdata), .busy(busy3)
    );

    // Registered-read RAM, latency 1
    logic [31:0] mem1 [256] = '{default: 32'h0};
    always @(posedge clk) begin
        if (ram_w_en) mem1[ram_addr[9:2]] <= ram_wdata;
        if (ram_r_en) ram_rdata <= mem1[ram_addr[9:2]];
    end

    // Registered-read RAM, latency 3
    logic [31:0] mem3 [256] = '{default: 32'h0};
    logic [31:0] p0 = 0, p1 = 0, p2 = 0;
    always @(posedge clk) begin
        if (r3_w_en) mem3[r3_addr[9:2]] <= r3_wdata;
        if (r3_r_en) p0 <= mem3[r3_addr[9:2]];
        p1 <= p0;
        p2 <= p1;
    end
    assign r3_rdata = p2;

    // Bench reference memory and scoreboard
    logic [31:0] tb_mem [256] = '{default: 32'h0};
    typedef struct packed {
        logic        port;   // 1 = I port
        logic [31:0] data;
    } sb_t;
    sb_t sb [$];

    // Ack monitor: pops the scoreboard and checks output invariants
    always @(negedge clk) begin
        sb_t e;
        if (!rst) begin
            n_tests++;
            if (d_ack && i_ack) begin
                n_fail++;
                $display("FAIL both_acks: d_ack=%b i_ack=%b required not both 1", d_ack, i_ack);
            end
            n_tests++;
            if ((!d_ack && d_rdata !== 32'h0) || (!i_ack && i_rdata !== 32'h0)) begin
                n_fail++;
                $display("FAIL rdata_idle: d_rdata=%h i_rdata=%h required 0 without ack",
                         d_rdata, i_rdata);
            end
            if (d_ack || i_ack) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ack: d_ack=%b i_ack=%b required no ack",
                             d_ack, i_ack);
                end else begin
                    e = sb.pop_front();
                    if (i_ack !== e.port || (e.port ? i_rdata : d_rdata) !== e.data) begin
                        n_fail++;
                        $display("FAIL sb_ack: port=%0d data=%h required port=%0d data=%h",
                                 i_ack, (i_ack ? i_rdata : d_rdata), e.port, e.data);
                    end
                end
            end
        end
    end

    // One transaction on the RAM_LAT=1 instance; call with the DUT idle, just
    // after a rising edge. perturb changes the requester's inputs mid-flight.
    task automatic run_txn(input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic perturb);
        sb_t         e;
        int          ack_k;
        int          en_cnt;
        logic [31:0] exp_addr;
        exp_addr = addr & 32'hFFFF_FFFC;
        e.port = port;
        e.data = we ? 32'h0 : tb_mem[addr[9:2]];
        if (we) tb_mem[addr[9:2]] = wdata;
        sb.push_back(e);
        if (port) begin
            i_req = 1; i_we = we; i_addr = addr; i_wdata = wdata;
        end else begin
            d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
        end
        ack_k  = 0;
        en_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ram_r_en || ram_w_en) begin
                en_cnt++;
                n_tests++;
                if (k != 1 || ram_w_en !== we || ram_r_en !== !we || ram_addr !== exp_addr ||
                    (we && ram_wdata !== wdata)) begin
                    n_fail++;
                    $display("FAIL issue: k=%0d w_en=%b r_en=%b addr=%h wdata=%h required k=1 we=%b addr=%h wdata=%h",
                             k, ram_w_en, ram_r_en, ram_addr, ram_wdata, we, exp_addr, wdata);
                end
            end
            if (k == 1 && perturb) begin
                if (port) begin i_addr = addr ^ 32'h34; i_wdata = ~wdata; end
                else      begin d_addr = addr ^ 32'h34; d_wdata = ~wdata; end
            end
            if (k == 2) begin
                n_tests++;
                if (ram_addr !== exp_addr || (we && ram_wdata !== wdata)) begin
                    n_fail++;
                    $display("FAIL addr_hold: addr=%h wdata=%h required addr=%h wdata=%h",
                             ram_addr, ram_wdata, exp_addr, wdata);
                end
            end
            n_tests++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy: k=%0d busy=%b required 1", k, busy);
            end
            if (d_ack || i_ack) begin
                ack_k = k;
                break;
            end
        end
        n_tests++;
        if (ack_k != 3) begin
            n_fail++;
            $display("FAIL latency: ack at cycle %0d required 3", ack_k);
        end
        n_tests++;
        if (en_cnt != 1) begin
            n_fail++;
            $display("FAIL enable_count: %0d pulses required 1", en_cnt);
        end
        @(posedge clk); #1;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        i_req = 0; i_we = 0; i_addr = 0; i_wdata = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, d_ack, i_ack, ram_r_en, ram_w_en} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/acks/enables=%b required 00000",
                     {busy, d_ack, i_ack, ram_r_en, ram_w_en});
        end
        n_tests++;
        if (ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ram: addr=%h wdata=%h required 0", ram_addr, ram_wdata);
        end
        n_tests++;
        if (d_rdata !== 32'h0 || i_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: d=%h i=%h required 0", d_rdata, i_rdata);
        end
        rst = 0;
    endtask

    task automatic test_write_read();
        run_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        run_txn(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
        run_txn(1'b0, 1'b0, 32'h13, 32'h0, 1'b0);
        run_txn(1'b1, 1'b1, 32'h40, 32'hCAFE0001, 1'b0);
        run_txn(1'b1, 1'b0, 32'h42, 32'h0, 1'b0);
    endtask

    task automatic test_latch();
        run_txn(1'b0, 1'b1, 32'h20, 32'hA5A5_1234, 1'b1);
        run_txn(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
        run_txn(1'b0, 1'b0, 32'h14, 32'h0, 1'b0);
    endtask

    task automatic test_arbitration();
        sb_t e;
        int  acks;
        int  i_acks;
        int  exp_i_acks;
        run_txn(1'b0, 1'b1, 32'h30, 32'h1111_2222, 1'b0);
        run_txn(1'b1, 1'b1, 32'h34, 32'h3333_4444, 1'b0);
        exp_i_acks = 0;
        for (int n = 0; n < 4; n++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            e.port = (n % 2 == 1);
`else
            e.port = 1'b0;
`endif
            e.data = e.port ? tb_mem[13] : tb_mem[12];
            if (e.port) exp_i_acks++;
            sb.push_back(e);
        end
        d_req = 1; d_we = 0; d_addr = 32'h30;
        i_req = 1; i_we = 0; i_addr = 32'h34;
        acks   = 0;
        i_acks = 0;
        for (int k = 0; k < 40 && acks < 4; k++) begin
            @(posedge clk); #1;
            if (d_ack || i_ack) acks++;
            if (i_ack) i_acks++;
        end
        @(posedge clk); #1;
        d_req = 0; i_req = 0; d_addr = 0; i_addr = 0;
        n_tests++;
        if (acks != 4) begin
            n_fail++;
            $display("FAIL arb_count: %0d acks required 4", acks);
        end
        n_tests++;
        if (i_acks != exp_i_acks) begin
            n_fail++;
            $display("FAIL arb_i_acks: %0d required %0d", i_acks, exp_i_acks);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic lat3_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rd);
        int          ack_k;
        int          en_cnt;
        logic [31:0] got;
        ack_k  = 0;
        en_cnt = 0;
        got    = 0;
        d3_req = 1; d3_we = we; d3_addr = addr; d3_wdata = wdata;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (r3_r_en || r3_w_en) en_cnt++;
            if (d3_ack) begin
                ack_k = k;
                got   = d3_rdata;
                break;
            end
        end
        n_tests++;
        if (ack_k != 5) begin
            n_fail++;
            $display("FAIL lat3_latency: ack at cycle %0d required 5", ack_k);
        end
        n_tests++;
        if (en_cnt != 1) begin
            n_fail++;
            $display("FAIL lat3_enable: %0d pulses required 1", en_cnt);
        end
        if (!we) begin
            n_tests++;
            if (got !== exp_rd) begin
                n_fail++;
                $display("FAIL lat3_data: %h required %h", got, exp_rd);
            end
        end
        @(posedge clk); #1;
        d3_req = 0; d3_we = 0; d3_addr = 0; d3_wdata = 0;
    endtask

    task automatic test_latency();
        lat3_txn(1'b1, 32'h50, 32'h0BAD_F00D, 32'h0);
        lat3_txn(1'b0, 32'h50, 32'h0, 32'h0BAD_F00D);
    endtask

    task automatic test_reset_mid();
        int stray;
        d_req = 1; d_we = 0; d_addr = 32'h10;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1;
        d_req = 0;
        #1;
        n_tests++;
        if ({busy, d_ack, i_ack, ram_r_en, ram_w_en} !== 5'b0 || ram_addr !== 32'h0 ||
            d_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset: ctrl=%b addr=%h rdata=%h required all 0",
                     {busy, d_ack, i_ack, ram_r_en, ram_w_en}, ram_addr, d_rdata);
        end
        #2;
        rst = 0;
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (d_ack || i_ack || busy) stray++;
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL after_reset: %0d active cycles required 0", stray);
        end
        run_txn(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_latch();
        test_arbitration();
        test_latency();
        test_reset_mid();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d acks outstanding required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
